hazard_flush_ctrl: RTL and testbench

Central hazard sequencer for the 5-stage pipeline. It detects load-use, control-transfer and data-memory-wait hazards, and drives the PC/IF-ID write enables, the IF/ID flush, the `flush` input of the control-zeroing stage (ID/EX bubble) and a whole-pipeline hold. It sits beside the ID stage, takes hazard inputs from ID, EX and MEM, and replaces the ad-hoc stall/flush wiring.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_flush_ctrl_load_use_detect.sv | 17 +
 rtl/hazard_flush_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_flush_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    FLUSH   = 2'd2,
    MEMWAIT = 2'd3
  } hz_state_t;

  localparam int REG_AW             = 5;
  localparam int BRANCH_PENALTY_DEF = 2;
  localparam int LOAD_USE_STALL_DEF = 1;
  localparam int CNT_W_DEF          = 3;

endpackage

// File: rtl/hazard_flush_ctrl_load_use_detect.sv
// Load-use comparator: a load in EX whose destination feeds a source of the instruction in ID.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              load_use
);

  // $zero is never a real dependency
  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Central stall/flush/hold sequencer for the 5-stage pipeline (Mealy outputs).
// Optional cycle counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_flush_ctrl
  import hazard_pkg::*;
#(
  parameter int BRANCH_PENALTY = BRANCH_PENALTY_DEF,
  parameter int LOAD_USE_STALL = LOAD_USE_STALL_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_jump,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              flush,
  output logic              pipe_hold,
  output logic [1:0]        state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_cycles
`endif
);

  hz_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             load_use;
  logic             mem_stall;

  load_use_detect u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use)
  );

  assign mem_stall = mem_req && !mem_ack;
  assign state_o   = state_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    flush      = 1'b0;
    pipe_hold  = 1'b0;

    case (state_reg)
      RUN, STALL: begin
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          flush      = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            state_next = FLUSH;
            cnt_next   = CNT_W'(BRANCH_PENALTY - 1);
          end else begin
            state_next = RUN;
            cnt_next   = '0;
          end
        end else if (state_reg == STALL) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          flush      = 1'b1;
          cnt_next   = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) state_next = RUN;
        end else if (mem_stall) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          state_next = MEMWAIT;
        end else if (load_use) begin
          // Stall beats a simultaneous jump; the jump is seen again once ID is released
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          flush      = 1'b1;
          if (LOAD_USE_STALL > 1) begin
            state_next = STALL;
            cnt_next   = CNT_W'(LOAD_USE_STALL - 1);
          end
        end else if (id_jump) begin
          ifid_flush = 1'b1;
        end
      end
      FLUSH: begin
        ifid_flush = 1'b1;
        flush      = 1'b1;
        if (mem_stall) begin
          pc_write  = 1'b0;
          pipe_hold = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) state_next = RUN;
        end
      end
      MEMWAIT: begin
        if (!mem_ack) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase

    // Reset forces a NOP front end regardless of state
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      flush      = 1'b1;
      pipe_hold  = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_reg, flush_cycles_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_reg <= '0;
      flush_cycles_reg <= '0;
    end else begin
      if (!pc_write)  stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (ifid_flush) flush_cycles_reg <= flush_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_cycles = flush_cycles_reg;
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl with default BRANCH_PENALTY=2, LOAD_USE_STALL=1.
module tb_hazard_flush_ctrl;
  import hazard_pkg::*;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, id_jump, ex_branch_taken, mem_req, mem_ack;
  logic       pc_write, ifid_write, ifid_flush, flush, pipe_hold;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int total = 0;
  int bad   = 0;

  hazard_flush_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .id_jump         (id_jump),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .flush           (flush),
    .pipe_hold       (pipe_hold),
    .state_o         (state_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_cycles    (flush_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, flush, pipe_hold, state_o}
  logic [6:0] obs;
  assign obs = {pc_write, ifid_write, ifid_flush, flush, pipe_hold, state_o};

  typedef struct packed {
    logic       rst;
    logic       mrd;
    logic [4:0] ert;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       jmp;
    logic       br;
    logic       mreq;
    logic       mack;
  } stim_t;

  function automatic stim_t mk(logic rst, logic mrd, logic [4:0] ert, logic [4:0] rs,
                               logic [4:0] rt, logic urt, logic jmp, logic br,
                               logic mreq, logic mack);
    stim_t s;
    s = '{rst, mrd, ert, rs, rt, urt, jmp, br, mreq, mack};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset           = s.rst;
    ex_mem_read     = s.mrd;
    ex_rt           = s.ert;
    id_rs           = s.rs;
    id_rt           = s.rt;
    id_uses_rt      = s.urt;
    id_jump         = s.jmp;
    ex_branch_taken = s.br;
    mem_req         = s.mreq;
    mem_ack         = s.mack;
  endtask

  localparam stim_t IDLE = '0;

  task automatic test_reset;
    stim_t s[3];
    logic [6:0] e[3];
    s[0] = mk(1,0,0,0,0,0,0,0,0,0);  e[0] = {5'b00110, 2'd0};
    s[1] = mk(1,0,0,0,0,0,0,0,0,0);  e[1] = {5'b00110, 2'd0};
    s[2] = IDLE;                     e[2] = {5'b11000, 2'd0};
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      #2;
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL reset[%0d] got=%b want=%b", i, obs, e[i]);
      end else $display("ok reset[%0d] outs=%b", i, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use;
    stim_t s[6];
    logic [6:0] e[6];
    s[0] = mk(0,1,8,8,0,0,0,0,0,0);  e[0] = {5'b00010, 2'd0};
    s[1] = IDLE;                     e[1] = {5'b11000, 2'd0};
    s[2] = mk(0,1,8,3,8,1,0,0,0,0);  e[2] = {5'b00010, 2'd0};
    s[3] = mk(0,1,8,3,8,0,0,0,0,0);  e[3] = {5'b11000, 2'd0};
    s[4] = mk(0,1,0,0,0,1,0,0,0,0);  e[4] = {5'b11000, 2'd0};
    s[5] = mk(0,0,8,8,8,1,0,0,0,0);  e[5] = {5'b11000, 2'd0};
    for (int i = 0; i < 6; i++) begin
      drive(s[i]);
      #2;
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL load_use[%0d] got=%b want=%b", i, obs, e[i]);
      end else $display("ok load_use[%0d] outs=%b", i, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch;
    stim_t s[3];
    logic [6:0] e[3];
    s[0] = mk(0,0,0,0,0,0,0,1,0,0);  e[0] = {5'b11110, 2'd0};
    s[1] = IDLE;                     e[1] = {5'b11110, 2'd2};
    s[2] = IDLE;                     e[2] = {5'b11000, 2'd0};
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      #2;
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL branch[%0d] got=%b want=%b", i, obs, e[i]);
      end else $display("ok branch[%0d] outs=%b", i, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_memwait;
    stim_t s[7];
    logic [6:0] e[7];
    s[0] = mk(0,0,0,0,0,0,0,0,1,0);  e[0] = {5'b00001, 2'd0};
    s[1] = mk(0,0,0,0,0,0,0,0,1,0);  e[1] = {5'b00001, 2'd3};
    s[2] = mk(0,0,0,0,0,0,0,0,1,0);  e[2] = {5'b00001, 2'd3};
    s[3] = mk(0,0,0,0,0,0,0,0,1,1);  e[3] = {5'b11000, 2'd3};
    s[4] = IDLE;                     e[4] = {5'b11000, 2'd0};
    s[5] = mk(0,0,0,0,0,0,0,0,1,1);  e[5] = {5'b11000, 2'd0};
    s[6] = IDLE;                     e[6] = {5'b11000, 2'd0};
    for (int i = 0; i < 7; i++) begin
      drive(s[i]);
      #2;
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL memwait[%0d] got=%b want=%b", i, obs, e[i]);
      end else $display("ok memwait[%0d] outs=%b", i, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_vs_load_use;
    stim_t s[3];
    logic [6:0] e[3];
    s[0] = mk(0,1,8,8,0,0,0,1,0,0);  e[0] = {5'b11110, 2'd0};
    s[1] = IDLE;                     e[1] = {5'b11110, 2'd2};
    s[2] = IDLE;                     e[2] = {5'b11000, 2'd0};
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      #2;
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL br_vs_lu[%0d] got=%b want=%b", i, obs, e[i]);
      end else $display("ok br_vs_lu[%0d] outs=%b", i, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump;
    stim_t s[4];
    logic [6:0] e[4];
    s[0] = mk(0,0,0,0,0,0,1,0,0,0);  e[0] = {5'b11100, 2'd0};
    s[1] = mk(0,1,5,5,0,0,1,0,0,0);  e[1] = {5'b00010, 2'd0};
    s[2] = mk(0,0,0,0,0,0,1,0,0,0);  e[2] = {5'b11100, 2'd0};
    s[3] = IDLE;                     e[3] = {5'b11000, 2'd0};
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      #2;
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL jump[%0d] got=%b want=%b", i, obs, e[i]);
      end else $display("ok jump[%0d] outs=%b", i, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_memwait;
    stim_t s[5];
    logic [6:0] e[5];
    s[0] = mk(0,0,0,0,0,0,0,1,0,0);  e[0] = {5'b11110, 2'd0};
    s[1] = mk(0,0,0,0,0,0,0,0,1,0);  e[1] = {5'b01111, 2'd2};
    s[2] = mk(0,0,0,0,0,0,0,0,1,0);  e[2] = {5'b01111, 2'd2};
    s[3] = mk(0,0,0,0,0,0,0,0,1,1);  e[3] = {5'b11110, 2'd2};
    s[4] = IDLE;                     e[4] = {5'b11000, 2'd0};
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      #2;
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL flush_mem[%0d] got=%b want=%b", i, obs, e[i]);
      end else $display("ok flush_mem[%0d] outs=%b", i, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_memwait;
    stim_t s[4];
    logic [6:0] e[4];
    s[0] = mk(0,0,0,0,0,0,0,0,1,0);  e[0] = {5'b00001, 2'd0};
    s[1] = mk(0,0,0,0,0,0,0,0,1,0);  e[1] = {5'b00001, 2'd3};
    s[2] = mk(1,0,0,0,0,0,0,0,1,0);  e[2] = {5'b00110, 2'd3};
    s[3] = IDLE;                     e[3] = {5'b11000, 2'd0};
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      #2;
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL rst_memwait[%0d] got=%b want=%b", i, obs, e[i]);
      end else $display("ok rst_memwait[%0d] outs=%b", i, obs);
`ifdef HAZARD_PERF_CNT_EN
      if (i == 3) begin
        total++;
        if (stall_cycles !== 32'd0) begin
          bad++;
          $display("FAIL perf_stall_after_reset got=%0d want=0", stall_cycles);
        end else $display("ok perf_stall_after_reset");
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  initial begin
    drive(mk(1,0,0,0,0,0,0,0,0,0));
    @(posedge clk); #1;
    test_reset;
    test_load_use;
    test_branch;
    test_memwait;
    test_branch_vs_load_use;
    test_jump;
    test_flush_memwait;
    test_reset_mid_memwait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
